// File: rtl/riscv_instr_byte_loader.sv
// Assembles 32-bit instruction words from an LSB-first byte stream and queues them in a small FIFO.
// Optional partial-word idle timeout is enabled by defining LOADER_TIMEOUT_EN.
module riscv_instr_byte_loader #(
    parameter int DEPTH          = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [7:0]               byte_in,
    input  logic                     byte_stb,
    output logic                     byte_rdy,
    output logic [31:0]              instr_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               word_count,
    output logic                     err_timeout
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    logic [1:0]    byte_cnt;
    logic [23:0]   partial;
    logic [31:0]   mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [7:0]    pop_count;
    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;
    logic          drop;

    // Handshakes: a byte moves when byte_stb && byte_rdy; a word moves when
    // instr_valid && instr_ready. Both sides sample at the rising clk edge.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign byte_rdy = !((byte_cnt == 2'd3) && full);
    assign accept   = byte_stb && byte_rdy && !flush;
    assign push     = accept && (byte_cnt == 2'd3);
    assign pop      = !empty && instr_ready && !flush;

    assign instr_valid = !empty;
    assign instr_data  = empty ? 32'h0 : mem[rd_ptr[PW-1:0]];
    assign fifo_level  = wr_ptr - rd_ptr;
    assign word_count  = pop_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 2'd0;
        end else if (flush) begin
            byte_cnt <= 2'd0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
        end else if (drop) begin
            byte_cnt <= 2'd0;
        end
    end

    // Only bytes 0..2 are stored; byte 3 goes straight into the FIFO with them.
    always_ff @(posedge clk) begin
        if (accept) begin
            case (byte_cnt)
                2'd0:    partial[7:0]   <= byte_in;
                2'd1:    partial[15:8]  <= byte_in;
                2'd2:    partial[23:16] <= byte_in;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= {byte_in, partial};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pop_count <= 8'd0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pop_count <= 8'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                pop_count <= pop_count + 8'd1;
            end
        end
    end

`ifdef LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] idle_cnt;
    logic            err_q;

    // The drop fires on the idle edge that would bring the count to TIMEOUT_CYCLES.
    assign drop        = !accept && !flush && (byte_cnt != 2'd0) && (idle_cnt == TO_LAST);
    assign err_timeout = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= drop;
            if (flush || accept || drop || (byte_cnt == 2'd0)) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`else
    assign drop = 1'b0;
    // Always false; keeps TIMEOUT_CYCLES referenced when the timeout is compiled out.
    assign err_timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_riscv_instr_byte_loader.sv
// Self-checking bench for riscv_instr_byte_loader: a queue-based reference model compared every
// cycle, plus directed literal checks of words, levels and counters.
module tb_riscv_instr_byte_loader;

  localparam int DEPTH = 2;
  localparam int TO    = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [7:0]  byte_in;
  logic        byte_stb;
  logic        byte_rdy;
  logic [31:0] instr_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  fifo_level;
  logic [7:0]  word_count;
  logic        err_timeout;

  riscv_instr_byte_loader #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .byte_in     (byte_in),
    .byte_stb    (byte_stb),
    .byte_rdy    (byte_rdy),
    .instr_data  (instr_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fifo_level  (fifo_level),
    .word_count  (word_count),
    .err_timeout (err_timeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: bytes fill a word LSB first; completed words wait in exp_q
  logic [31:0] exp_q[$];
  logic [31:0] part_m = 32'h0;
  int          bcnt_m = 0;
  int          wc_m = 0;
  int          idle_m = 0;
  bit          err_m = 1'b0;

  always @(negedge rst_n) begin
    exp_q.delete();
    bcnt_m = 0;
    wc_m   = 0;
    idle_m = 0;
    err_m  = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      bit can_take;
      can_take = !(bcnt_m == 3 && exp_q.size() == DEPTH);
      err_m = 1'b0;
      if (flush) begin
        exp_q.delete();
        bcnt_m = 0;
        wc_m   = 0;
        idle_m = 0;
      end else begin
        if (exp_q.size() > 0 && instr_ready) begin
          void'(exp_q.pop_front());
          wc_m = (wc_m + 1) % 256;
        end
        if (byte_stb && can_take) begin
          part_m[8*bcnt_m +: 8] = byte_in;
          if (bcnt_m == 3) exp_q.push_back(part_m);
          bcnt_m = (bcnt_m + 1) % 4;
          idle_m = 0;
        end
`ifdef LOADER_TIMEOUT_EN
        else if (bcnt_m != 0) begin
          idle_m++;
          if (idle_m == TO) begin
            bcnt_m = 0;
            idle_m = 0;
            err_m  = 1'b1;
          end
        end
`endif
      end
    end
  end

  // compare process, plus a record of words seen leaving the FIFO
  logic [31:0] got_q[$];

  always @(negedge clk) begin
    chk("byte_rdy", 32'(byte_rdy), 32'(!(bcnt_m == 3 && exp_q.size() == DEPTH)));
    chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
    chk("instr_data", instr_data, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
    chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
    chk("word_count", 32'(word_count), 32'(wc_m));
    chk("err_timeout", 32'(err_timeout), 32'(err_m));
    if (rst_n && !flush && instr_valid && instr_ready) got_q.push_back(instr_data);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    int n = 0;
    byte_in  = b;
    byte_stb = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = byte_rdy;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        chk("send_byte_budget", 32'(n), 32'd200);
        done = 1'b1;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    byte_stb = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; byte_in = 8'h0; byte_stb = 1'b0; instr_ready = 1'b0;
    repeat (3) step();
    chk("rst_byte_rdy", 32'(byte_rdy), 32'd1);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_data", instr_data, 32'h0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    step();

    // 1: single word, back-to-back bytes, consumer ready
    instr_ready = 1'b1;
    send_word(32'h00500013);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_data", instr_data, 32'h00500013);
    step();
    chk("t1_word_count", 32'(word_count), 32'd1);
    chk("t1_valid_after_pop", 32'(instr_valid), 32'd0);

    // 2: fill FIFO, third word stalls at byte 3, then drain in order
    instr_ready = 1'b0;
    got_q.delete();
    send_word(32'h11223344);
    send_word(32'h55667788);
    send_byte(8'hCC); send_byte(8'hBB); send_byte(8'hAA);
    byte_in = 8'h99;
    step(); step();
    chk("t2_level_full", 32'(fifo_level), 32'd2);
    chk("t2_byte_rdy_low", 32'(byte_rdy), 32'd0);
    instr_ready = 1'b1;
    send_byte(8'h99);
    byte_stb = 1'b0;
    step();
    chk("t2_level_drained", 32'(fifo_level), 32'd0);
    chk("t2_pop_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      chk("t2_order0", got_q[0], 32'h11223344);
      chk("t2_order1", got_q[1], 32'h55667788);
      chk("t2_order2", got_q[2], 32'h99AABBCC);
    end
    chk("t2_word_count", 32'(word_count), 32'd4);

    // 3: push and pop on the same edge at level 1
    instr_ready = 1'b0;
    got_q.delete();
    send_word(32'hDEADBEEF);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    instr_ready = 1'b1;
    send_byte(8'h04);
    byte_stb = 1'b0;
    chk("t3_level_same", 32'(fifo_level), 32'd1);
    chk("t3_head", instr_data, 32'h04030201);
    step();
    chk("t3_pop_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      chk("t3_order0", got_q[0], 32'hDEADBEEF);
      chk("t3_order1", got_q[1], 32'h04030201);
    end
    chk("t3_word_count", 32'(word_count), 32'd6);

    // 4: flush mid-word with a queued word, then a clean word
    instr_ready = 1'b0;
    send_word(32'hCAFEF00D);
    send_byte(8'h5A); send_byte(8'hA5);
    byte_stb = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_level", 32'(fifo_level), 32'd0);
    chk("t4_word_count", 32'(word_count), 32'd0);
    chk("t4_valid", 32'(instr_valid), 32'd0);
    send_word(32'h0000A0B7);
    chk("t4_clean_word", instr_data, 32'h0000A0B7);
    instr_ready = 1'b1;
    step();
    chk("t4_word_count_after", 32'(word_count), 32'd1);

    // 5: idle after a single byte
    instr_ready = 1'b0;
    send_byte(8'hAA);
    byte_stb = 1'b0;
`ifdef LOADER_TIMEOUT_EN
    begin
      int pulses = 0;
      int at = 0;
      for (int i = 1; i <= 12; i++) begin
        step();
        if (err_timeout) begin
          pulses++;
          at = i;
        end
      end
      chk("t5_pulse_count", 32'(pulses), 32'd1);
      chk("t5_pulse_cycle", 32'(at), 32'(TO));
    end
    send_word(32'h12345678);
    chk("t5_word_after_drop", instr_data, 32'h12345678);
`else
    repeat (20) step();
    chk("t5_no_err", 32'(err_timeout), 32'd0);
    send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    byte_stb = 1'b0;
    chk("t5_held_word", instr_data, 32'hDDCCBBAA);
`endif
    instr_ready = 1'b1;
    step();
    chk("t5_word_count", 32'(word_count), 32'd2);

    // 6: asynchronous reset mid-word with a valid head
    instr_ready = 1'b0;
    send_word(32'hFEEDFACE);
    send_byte(8'h11); send_byte(8'h22);
    byte_stb = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(instr_valid), 32'd0);
    chk("t6_data", instr_data, 32'h0);
    chk("t6_level", 32'(fifo_level), 32'd0);
    chk("t6_word_count", 32'(word_count), 32'd0);
    chk("t6_byte_rdy", 32'(byte_rdy), 32'd1);
    chk("t6_err", 32'(err_timeout), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step();
    send_word(32'h00100093);
    chk("t6_post_reset_word", instr_data, 32'h00100093);
    instr_ready = 1'b1;
    step();
    chk("t6_post_reset_count", 32'(word_count), 32'd1);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
